// File: rtl/count_sample_fifo.sv
// Captures counter samples (value, direction, wrap flag) into a small FWFT FIFO
// and flags counter wrap events and dropped captures.
module count_sample_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] qd,
  input  logic                  up_down,
  input  logic                  sample,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_dir,
  output logic                  m_wrap,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  input  logic                  ovf_clear,
  output logic                  wrap_evt
);

  localparam int ADDR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_WIDTH = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [DATA_WIDTH-1:0]  qd_q;
  logic                   wrap_pending;

  logic                   wrap_det;
  logic                   wrap_flag;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [CNT_WIDTH-1:0]   count_nxt;

  // A wrap is only the exact terminal-to-terminal step in the current direction;
  // loads or clears that jump elsewhere never qualify.
  always_comb begin
    wrap_det = 1'b0;
    if (up_down && (qd_q == ALL_ONES) && (qd == ZERO))
      wrap_det = 1'b1;
    else if (!up_down && (qd_q == ZERO) && (qd == ALL_ONES))
      wrap_det = 1'b1;
  end

  always_comb begin
    wrap_flag = wrap_pending | wrap_det;
    pop       = m_valid & m_ready;
    push      = sample & ((count != FULL_CNT) | pop);
    drop      = sample & (count == FULL_CNT) & ~pop;
  end

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_WIDTH'(1);
      2'b01:   count_nxt = count - CNT_WIDTH'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is intentionally not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {wrap_flag, up_down, qd};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qd_q         <= '0;
      wrap_pending <= 1'b0;
      wrap_evt     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      m_valid      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      qd_q     <= qd;
      wrap_evt <= wrap_det;

      // A successful push absorbs any pending or same-cycle wrap; a drop keeps it.
      if (push)
        wrap_pending <= 1'b0;
      else if (wrap_det)
        wrap_pending <= 1'b1;

      if (push)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);

      count   <= count_nxt;
      m_valid <= (count_nxt != '0);

      if (drop)
        overflow <= 1'b1;
      else if (ovf_clear)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    {m_wrap, m_dir, m_data} = mem[rd_ptr];
  end

endmodule

// File: tb/tb_count_sample_fifo.sv
// Directed scoreboard bench for count_sample_fifo: expected entries are queued
// at capture time and compared by a monitor on every accepted handshake.
module tb_count_sample_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] qd;
  logic       up_down;
  logic       sample;
  logic [7:0] m_data;
  logic       m_dir;
  logic       m_wrap;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clear;
  logic       wrap_evt;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  count_sample_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .qd(qd), .up_down(up_down), .sample(sample),
    .m_data(m_data), .m_dir(m_dir), .m_wrap(m_wrap), .m_valid(m_valid),
    .m_ready(m_ready), .count(count), .overflow(overflow),
    .ovf_clear(ovf_clear), .wrap_evt(wrap_evt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic wrap, input logic dir, input logic [7:0] data);
    exp_q.push_back({wrap, dir, data});
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      logic [9:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pop: got %0h expected none", {m_wrap, m_dir, m_data});
      end else begin
        e = exp_q.pop_front();
        if ({m_wrap, m_dir, m_data} !== e) begin
          n_err++;
          $display("FAIL pop_entry: got wrap=%0b dir=%0b data=%0h expected wrap=%0b dir=%0b data=%0h",
                   m_wrap, m_dir, m_data, e[9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drain(input int n);
    m_ready = 1'b1;
    repeat (n) cyc();
    m_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; qd = 8'h00; up_down = 1'b1; sample = 1'b0;
    m_ready = 1'b0; ovf_clear = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Reset release, idle
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_count", count, 0);
      chk("idle_valid", m_valid, 0);
      chk("idle_ovf", overflow, 0);
      chk("idle_wrap_evt", wrap_evt, 0);
    end

    // Single capture
    qd = 8'h2A; sample = 1'b1; exp_push(1'b0, 1'b1, 8'h2A);
    cyc();
    sample = 1'b0;
    chk("single_valid", m_valid, 1);
    chk("single_count", count, 1);
    chk("single_data", m_data, 8'h2A);
    chk("single_dir", m_dir, 1);
    chk("single_wrap", m_wrap, 0);
    cyc();
    chk("single_hold_data", m_data, 8'h2A);
    drain(1);
    chk("single_after_pop_valid", m_valid, 0);
    chk("single_after_pop_count", count, 0);

    // Up-wrap
    qd = 8'hFE; cyc();
    qd = 8'hFF; cyc();
    chk("upwrap_no_evt_early", wrap_evt, 0);
    qd = 8'h00; cyc();
    chk("upwrap_evt", wrap_evt, 1);
    cyc();
    chk("upwrap_evt_single", wrap_evt, 0);
    qd = 8'h05; sample = 1'b1; exp_push(1'b1, 1'b1, 8'h05); cyc();
    qd = 8'h06; exp_push(1'b0, 1'b1, 8'h06); cyc();
    sample = 1'b0;
    chk("upwrap_count", count, 2);
    drain(2);
    chk("upwrap_drained", count, 0);

    // Down-wrap
    up_down = 1'b0;
    qd = 8'h01; cyc();
    qd = 8'h00; cyc();
    qd = 8'hFF; cyc();
    chk("dnwrap_evt", wrap_evt, 1);
    cyc();
    chk("dnwrap_evt_single", wrap_evt, 0);
    qd = 8'h05; sample = 1'b1; exp_push(1'b1, 1'b0, 8'h05); cyc();
    qd = 8'h06; exp_push(1'b0, 1'b0, 8'h06); cyc();
    sample = 1'b0;
    drain(2);
    chk("dnwrap_drained", count, 0);
    up_down = 1'b1;

    // Fill and overflow
    sample = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      qd = 8'(i);
      if (i <= 4) exp_push(1'b0, 1'b1, 8'(i));
      cyc();
    end
    sample = 1'b0;
    chk("fill_count", count, 4);
    chk("fill_ovf", overflow, 1);
    chk("fill_valid", m_valid, 1);
    drain(4);
    chk("fill_drained", count, 0);
    chk("fill_ovf_sticky", overflow, 1);
    ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Drop in the same cycle as ovf_clear keeps overflow set
    sample = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      qd = 8'(i + 16); exp_push(1'b0, 1'b1, 8'(i + 16)); cyc();
    end
    qd = 8'h30; ovf_clear = 1'b1; cyc();
    sample = 1'b0; ovf_clear = 1'b0;
    chk("drop_beats_clear", overflow, 1);
    ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
    chk("ovf_cleared2", overflow, 0);
    drain(4);

    // Full with simultaneous push/pop
    sample = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      qd = 8'(i); exp_push(1'b0, 1'b1, 8'(i)); cyc();
    end
    qd = 8'h09; m_ready = 1'b1; exp_push(1'b0, 1'b1, 8'h09); cyc();
    sample = 1'b0; m_ready = 1'b0;
    chk("full_pp_count", count, 4);
    chk("full_pp_ovf", overflow, 0);
    drain(4);
    chk("full_pp_drained", count, 0);

    // Reset mid-stream with a pending wrap
    sample = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      qd = 8'(i); cyc();
    end
    sample = 1'b0;
    qd = 8'hFF; cyc();
    qd = 8'h00; cyc();
    chk("pre_reset_count", count, 3);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("reset_count", count, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_wrap_evt", wrap_evt, 0);
    qd = 8'h10; sample = 1'b1; exp_push(1'b0, 1'b1, 8'h10); cyc();
    sample = 1'b0;
    chk("post_reset_count", count, 1);
    chk("post_reset_wrap", m_wrap, 0);
    drain(1);
    chk("post_reset_drained", count, 0);
    cyc();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
